// File: rtl/am_argmax_search_pkg.sv
// -----------------------------------------------------------------------------
// hdc_am_pkg
// Shared types and defaults for the associative-memory search stage of the
// sparse HDC inference path.
//   CLASS_W          : width of a class index / ground-truth label
//   DEF_NUM_CLASSES  : default number of class hypervectors per query
//   DEF_SCORE_W      : default width of an unsigned similarity score
//   class_idx_t      : class index type
//   am_search_state_t: search FSM state encoding
// Optional feature macro used by the files that import this package:
//   AM_TOP2_MARGIN_EN (runner-up score and best/runner-up margin outputs)
// -----------------------------------------------------------------------------
package hdc_am_pkg;

    localparam int unsigned CLASS_W         = 5;
    localparam int unsigned DEF_NUM_CLASSES = 26;
    localparam int unsigned DEF_SCORE_W     = 10;

    typedef logic [CLASS_W-1:0] class_idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } am_search_state_t;

endpackage

// File: rtl/am_argmax_search_if.sv
// -----------------------------------------------------------------------------
// am_argmax_search_if
// Query/score/result bundle of the argmax search stage.
//   Request side : start, correct_class_in, score_valid, score
//   Result side  : busy, inference_valid, class_inference, correct_class,
//                  best_score (+ second_score, margin with AM_TOP2_MARGIN_EN)
// Modports:
//   master : upstream driver / result consumer
//   slave  : the search stage itself
// Optional feature macro: AM_TOP2_MARGIN_EN
// -----------------------------------------------------------------------------
interface am_argmax_search_if
    import hdc_am_pkg::*;
#(
    parameter int unsigned SCORE_W = DEF_SCORE_W
) ();

    logic               start;
    class_idx_t         correct_class_in;
    logic               score_valid;
    logic [SCORE_W-1:0] score;

    logic               busy;
    logic               inference_valid;
    class_idx_t         class_inference;
    class_idx_t         correct_class;
    logic [SCORE_W-1:0] best_score;
`ifdef AM_TOP2_MARGIN_EN
    logic [SCORE_W-1:0] second_score;
    logic [SCORE_W-1:0] margin;
`endif

`ifdef AM_TOP2_MARGIN_EN
    modport master (
        output start, correct_class_in, score_valid, score,
        input  busy, inference_valid, class_inference, correct_class,
               best_score, second_score, margin
    );

    modport slave (
        input  start, correct_class_in, score_valid, score,
        output busy, inference_valid, class_inference, correct_class,
               best_score, second_score, margin
    );
`else
    modport master (
        output start, correct_class_in, score_valid, score,
        input  busy, inference_valid, class_inference, correct_class,
               best_score
    );

    modport slave (
        input  start, correct_class_in, score_valid, score,
        output busy, inference_valid, class_inference, correct_class,
               best_score
    );
`endif

endinterface

// File: rtl/am_argmax_search_max_update.sv
// -----------------------------------------------------------------------------
// am_max_update
// Combinational compare/select of the running {best, idx} (and runner-up with
// AM_TOP2_MARGIN_EN) against the incoming {score, counter}.
//   best, idx      : current best score and its class index
//   second         : current runner-up score (AM_TOP2_MARGIN_EN only)
//   score, counter : incoming score and the class it belongs to
//   best_nxt, idx_nxt, second_nxt : updated values
// The first class of a query always takes the best slot; afterwards only a
// strictly greater score replaces it, so ties keep the lowest class index.
// Optional feature macro: AM_TOP2_MARGIN_EN
// -----------------------------------------------------------------------------
module am_max_update
    import hdc_am_pkg::*;
#(
    parameter int unsigned SCORE_W = DEF_SCORE_W
) (
    input  logic [SCORE_W-1:0] best,
    input  class_idx_t         idx,
`ifdef AM_TOP2_MARGIN_EN
    input  logic [SCORE_W-1:0] second,
    output logic [SCORE_W-1:0] second_nxt,
`endif
    input  logic [SCORE_W-1:0] score,
    input  class_idx_t         counter,
    output logic [SCORE_W-1:0] best_nxt,
    output class_idx_t         idx_nxt
);

    logic first;
    logic take_best;

    assign first     = (counter == '0);
    assign take_best = first || (score > best);

    always_comb begin
        best_nxt = best;
        idx_nxt  = idx;
        if (take_best) begin
            best_nxt = score;
            idx_nxt  = counter;
        end
    end

`ifdef AM_TOP2_MARGIN_EN
    // The displaced best becomes the runner-up; on the first class there is
    // no previous best, so the runner-up starts from zero.
    always_comb begin
        second_nxt = second;
        if (take_best) begin
            second_nxt = first ? '0 : best;
        end else if (score == best) begin
            second_nxt = score;
        end else if (score > second) begin
            second_nxt = score;
        end
    end
`endif

endmodule

// File: rtl/am_argmax_search.sv
// -----------------------------------------------------------------------------
// am_argmax_search
// Associative-memory search stage: consumes one similarity score per class in
// class order 0..NUM_CLASSES-1, tracks the running maximum and reports the
// winning class with the latched ground-truth label. inference_valid pulses
// for the single DONE cycle and feeds the accuracy tally directly.
// Ports:
//   clk  : clock
//   nrst : asynchronous active-low reset
//   bus  : am_argmax_search_if.slave
//          (start/correct_class_in honoured in IDLE only,
//           score_valid/score honoured in SEARCH only,
//           busy, inference_valid, class_inference, correct_class, best_score,
//           second_score/margin with AM_TOP2_MARGIN_EN)
// Parameters: NUM_CLASSES (2..32), SCORE_W
// Optional feature macro: AM_TOP2_MARGIN_EN
// -----------------------------------------------------------------------------
module am_argmax_search
    import hdc_am_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int unsigned SCORE_W     = DEF_SCORE_W
) (
    input  logic             clk,
    input  logic             nrst,
    am_argmax_search_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SEARCH = SEARCH;
    localparam logic [1:0] ST_DONE   = DONE;

    localparam class_idx_t LAST_IDX = class_idx_t'(NUM_CLASSES - 1);

    logic [1:0]         state;
    class_idx_t         counter;
    logic [SCORE_W-1:0] best_q;
    class_idx_t         idx_q;
    class_idx_t         label_q;
    logic               valid_q;

    logic [SCORE_W-1:0] best_nxt;
    class_idx_t         idx_nxt;

`ifdef AM_TOP2_MARGIN_EN
    logic [SCORE_W-1:0] second_q;
    logic [SCORE_W-1:0] margin_q;
    logic [SCORE_W-1:0] second_nxt;
`endif

    am_max_update #(
        .SCORE_W (SCORE_W)
    ) u_max_update (
        .best       (best_q),
        .idx        (idx_q),
`ifdef AM_TOP2_MARGIN_EN
        .second     (second_q),
        .second_nxt (second_nxt),
`endif
        .score      (bus.score),
        .counter    (counter),
        .best_nxt   (best_nxt),
        .idx_nxt    (idx_nxt)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= ST_IDLE;
            counter  <= '0;
            best_q   <= '0;
            idx_q    <= '0;
            label_q  <= '0;
            valid_q  <= 1'b0;
`ifdef AM_TOP2_MARGIN_EN
            second_q <= '0;
            margin_q <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state    <= ST_SEARCH;
                        label_q  <= bus.correct_class_in;
                        counter  <= '0;
                        best_q   <= '0;
`ifdef AM_TOP2_MARGIN_EN
                        second_q <= '0;
                        margin_q <= '0;
`endif
                    end
                end
                ST_SEARCH: begin
                    if (bus.score_valid) begin
                        best_q  <= best_nxt;
                        idx_q   <= idx_nxt;
                        counter <= counter + 1'b1;
`ifdef AM_TOP2_MARGIN_EN
                        second_q <= second_nxt;
                        // Tracked on every accept so it is already final when
                        // the DONE cycle presents inference_valid.
                        margin_q <= best_nxt - second_nxt;
`endif
                        if (counter == LAST_IDX) begin
                            state   <= ST_DONE;
                            valid_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy            = (state != ST_IDLE);
    assign bus.inference_valid = valid_q;
    assign bus.class_inference = idx_q;
    assign bus.correct_class   = label_q;
    assign bus.best_score      = best_q;
`ifdef AM_TOP2_MARGIN_EN
    assign bus.second_score    = second_q;
    assign bus.margin          = margin_q;
`endif

endmodule

// File: tb/tb_am_argmax_search.sv
// -----------------------------------------------------------------------------
// tb_am_argmax_search
// Table-driven bench for am_argmax_search: query records are applied in a
// loop, expected results queue up when a query is launched and are checked
// when inference_valid appears. Hand-written sequences cover ignored inputs
// and reset mid-search. Runner-up/margin checks follow AM_TOP2_MARGIN_EN.
// -----------------------------------------------------------------------------
module tb_am_argmax_search;
    import hdc_am_pkg::*;

    localparam int unsigned NC = 26;
    localparam int unsigned SW = 10;

    typedef struct {
        logic [4:0]  cls;
        int unsigned mul;
        int unsigned base;
        int          hi1_idx;
        int unsigned hi1_val;
        int          hi2_idx;
        int unsigned hi2_val;
        bit          bubbles;
        int unsigned exp_class;
        int unsigned exp_best;
        int unsigned exp_second;
        int unsigned exp_margin;
    } vec_t;

    logic clk;
    logic nrst;

    am_argmax_search_if #(.SCORE_W(SW)) bus ();

    am_argmax_search #(
        .NUM_CLASSES (NC),
        .SCORE_W     (SW)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    vec_t        sb[$];
    vec_t        vecs[8];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] score_of(input vec_t v, input int unsigned i);
        if (int'(i) == v.hi1_idx) return SW'(v.hi1_val);
        if (int'(i) == v.hi2_idx) return SW'(v.hi2_val);
        return SW'(v.base + i * v.mul);
    endfunction

    // Result scoreboard: every inference_valid must match a launched query.
    always @(negedge clk) begin
        if (bus.inference_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                check("class_inference", bus.class_inference, e.exp_class);
                check("best_score", bus.best_score, e.exp_best);
                check("correct_class", bus.correct_class, e.cls);
`ifdef AM_TOP2_MARGIN_EN
                check("second_score", bus.second_score, e.exp_second);
                check("margin", bus.margin, e.exp_margin);
`endif
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_valid"}, bus.inference_valid, 0);
        check({tag, "_class"}, bus.class_inference, 0);
        check({tag, "_best"}, bus.best_score, 0);
        check({tag, "_label"}, bus.correct_class, 0);
`ifdef AM_TOP2_MARGIN_EN
        check({tag, "_second"}, bus.second_score, 0);
        check({tag, "_margin"}, bus.margin, 0);
`endif
    endtask

    // Launch a query and stream all scores. Caller is at posedge+1.
    task automatic run_query(input vec_t v, input bit mid_start, input bit done_start);
        bus.start            = 1'b1;
        bus.correct_class_in = v.cls;
        sb.push_back(v);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int unsigned i = 0; i < NC; i++) begin
            bus.score_valid = 1'b1;
            bus.score       = score_of(v, i);
            if (mid_start && i == 10) begin
                bus.start            = 1'b1;
                bus.correct_class_in = 5'd12;
            end
            check("busy_search", bus.busy, 1);
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (i != NC - 1) begin
                check("early_valid", bus.inference_valid, 0);
                if (v.bubbles && (i % 5) == 4) begin
                    for (int unsigned b = 0; b < 3; b++) begin
                        bus.score_valid = 1'b0;
                        bus.score       = '1;
                        check("busy_bubble", bus.busy, 1);
                        @(posedge clk); #1;
                        check("bubble_valid", bus.inference_valid, 0);
                    end
                end
            end
        end
        bus.score_valid = 1'b0;
        check("valid_latency", bus.inference_valid, 1);
        check("busy_done", bus.busy, 1);
        if (done_start) begin
            bus.start            = 1'b1;
            bus.correct_class_in = 5'd12;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("valid_width", bus.inference_valid, 0);
        check("busy_idle", bus.busy, 0);
        check("label_hold", bus.correct_class, v.cls);
        if (done_start) begin
            @(posedge clk); #1;
            check("done_start_ignored", bus.busy, 0);
        end
    endtask

    initial begin
        //        cls  mul base hi1 v1   hi2 v2   bub  cls best sec marg
        vecs[0] = '{5'd7, 3, 0,  7, 200, -1,   0, 1'b0,  7, 200,  75, 125};
        vecs[1] = '{5'd2, 0, 10, 4, 150, 19, 150, 1'b0,  4, 150, 150,   0};
        vecs[2] = '{5'd7, 3, 0,  7, 200, -1,   0, 1'b1,  7, 200,  75, 125};
        vecs[3] = '{5'd0, 0, 5,  3,  90,  8, 120, 1'b0,  8, 120,  90,  30};
        vecs[4] = '{5'd9, 0, 5,  3, 120,  8, 120, 1'b0,  3, 120, 120,   0};
        vecs[5] = '{5'd31,0, 0, -1,   0, -1,   0, 1'b0,  0,   0,   0,   0};
        vecs[6] = '{5'd1, 0, 1,  0, 500, -1,   0, 1'b0,  0, 500,   1, 499};
        vecs[7] = '{5'd25,3, 0, 25,1023, -1,   0, 1'b0, 25,1023,  72, 951};

        bus.start            = 1'b0;
        bus.correct_class_in = '0;
        bus.score_valid      = 1'b0;
        bus.score            = '0;
        nrst                 = 1'b0;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("post_reset");

        for (int unsigned k = 0; k < 8; k++) begin
            run_query(vecs[k], 1'b0, 1'b0);
            @(posedge clk); #1;
        end

        // Scores offered in IDLE must not disturb the held result of vecs[7].
        for (int unsigned k = 0; k < 4; k++) begin
            bus.score_valid = 1'b1;
            bus.score       = SW'(k + 1);
            @(posedge clk); #1;
            check("idle_busy", bus.busy, 0);
            check("idle_best_hold", bus.best_score, 1023);
            check("idle_class_hold", bus.class_inference, 25);
        end
        bus.score_valid = 1'b0;

        // start while busy (mid-search and in DONE) is ignored.
        run_query(vecs[0], 1'b1, 1'b1);
        @(posedge clk); #1;

        // Reset after 10 scores aborts the query without a pulse.
        bus.start            = 1'b1;
        bus.correct_class_in = 5'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
            bus.score_valid = 1'b1;
            bus.score       = score_of(vecs[0], i);
            @(posedge clk); #1;
        end
        nrst = 1'b0;
        #1;
        check_all_zero("abort");
        bus.score_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("abort_hold");
        nrst = 1'b1;
        @(posedge clk); #1;
        run_query(vecs[3], 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/am_argmax_search.md
Name: am_argmax_search

Overview:
- Associative-memory search stage in the sparse HDC inference path. It sits directly upstream of the accuracy tally.
- Consumes a stream of per-class similarity scores, one per class, from the AM similarity datapath.
- Tracks the running maximum and emits the winning class index, together with the latched ground-truth label.
- Its one-cycle inference_valid pulse drives the tally's tallying_accuracy input; class_inference and correct_class connect straight through.

Parameters:
- NUM_CLASSES, 26, number of class hypervectors scored per query; legal range 2..32.
- SCORE_W, 10, width of an unsigned similarity score (popcount of the AND overlap).

Ports:
- clk, input, 1, clock.
- nrst, input, 1, reset: asynchronous, active-low.
- start, input, 1, begin a new query search; honoured only in IDLE.
- correct_class_in, input, 5, ground-truth label for the query; sampled on an accepted start.
- score_valid, input, 1, score is valid this cycle; honoured only in SEARCH.
- score, input, SCORE_W, similarity score of the current class. Classes arrive strictly in order 0..NUM_CLASSES-1.
- busy, output, 1, high in SEARCH and DONE.
- inference_valid, output, 1, one-cycle pulse when the result is final.
- class_inference, output, 5, index of the best-scoring class.
- correct_class, output, 5, latched ground-truth label.
- best_score, output, SCORE_W, score of the winning class.

Behaviour:
- Reset: FSM enters IDLE. All outputs are 0, the class counter is 0 and the internal best register is 0.
- Reset asserted mid-search aborts the query. No inference_valid pulse is produced.
- FSM states:
  - IDLE -> SEARCH on start. On that edge: latch correct_class_in, clear counter and best_score.
  - SEARCH -> DONE on an accepted score when counter == NUM_CLASSES-1.
  - DONE -> IDLE unconditionally after 1 cycle.
- Accepting a score in SEARCH (score_valid=1):
  - If counter == 0, or score > best_score (strictly greater), then best_score <= score and class_inference <= counter.
  - counter increments every accepted score.
- Ties: the lowest class index wins, because only a strictly greater score replaces the current best.
- Bubbles: score_valid=0 in SEARCH stalls the search. State is unchanged and there is no timeout.
- Timing:
  - inference_valid is high for exactly the DONE cycle, i.e. the cycle after the last score is accepted.
  - Minimum query time is NUM_CLASSES+2 cycles, from start to the cycle after inference_valid.
- Ignored inputs:
  - start while busy is ignored; the latched correct_class is not disturbed.
  - score_valid in IDLE or DONE is ignored.
  - start asserted in the DONE cycle is ignored. Upstream re-issues start in IDLE.
- Output hold: class_inference, best_score and correct_class are registered. They hold their values after DONE until the next accepted start.
- Widths: the counter is 5 bits and compares against NUM_CLASSES-1 (cast to 5 bits). Score comparison is unsigned.

Optional Feature:
- Macro: AM_TOP2_MARGIN_EN.
- When defined:
  - Adds outputs second_score [SCORE_W] and margin [SCORE_W].
  - second_score tracks the runner-up. On a new best, second <= old best. Otherwise, if score > second, second <= score.
  - On a tie with the best, second <= score.
  - margin = best_score - second_score, registered, and valid with inference_valid. Both outputs reset to 0 and are cleared on start.
- When undefined: these ports and registers are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package hdc_am_pkg:
  - CLASS_W = 5.
  - Default NUM_CLASSES and SCORE_W.
  - Typedef class_idx_t (logic [CLASS_W-1:0]).
  - Typedef am_search_state_t enum {IDLE, SEARCH, DONE}.
- Sub-module am_max_update: combinational compare/select of {best, idx} (plus second when AM_TOP2_MARGIN_EN is defined) against the incoming {score, counter}. The FSM and registers stay in the top module.

Test Plan:
- Basic argmax: start with correct_class_in=7, scores i*3 except class 7=200, contiguous -> inference_valid one cycle after the 26th score; class_inference=7, best_score=200, correct_class=7.
- Tie: classes 4 and 19 both score 150, all others 10 -> class_inference=4, best_score=150.
- Bubbles: same stream as the basic test with score_valid low for 3 cycles after every 5th score -> identical result; inference_valid exactly 1 cycle after the last score; busy high throughout.
- Ignored inputs: start pulsed mid-search with correct_class_in=12, and score_valid=1 in IDLE -> correct_class stays 7; no state change from the IDLE scores.
- Reset mid-operation: nrst low after 10 scores -> all outputs 0, no pulse. A full query after release yields a correct fresh result.
- AM_TOP2_MARGIN_EN: scores {class3=90, class8=120, others 5} -> second_score=90, margin=30. A tie at 120 gives margin=0.
